// File: rtl/frame_clear_ctrl.sv
// Frame/Z-buffer clear sequencer: sweeps every pixel with CLEAR_COLOR/CLEAR_Z on request,
// and otherwise forwards rasterizer writes to the BRAMs through one register stage.
module frame_clear_ctrl #(
    parameter int          NUM_PIXELS  = 76800,
    parameter int          ADDR_W      = 17,
    parameter logic [11:0] CLEAR_COLOR = 12'h000,
    parameter logic [7:0]  CLEAR_Z     = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear_req,
    output logic              o_busy,
    output logic              o_clear_done,
    output logic              o_err_overlap,
    input  logic              i_rast_fb_we,
    input  logic [ADDR_W-1:0] i_rast_fb_addr,
    input  logic [11:0]       i_rast_fb_pixel,
    input  logic              i_rast_zb_we,
    input  logic [ADDR_W-1:0] i_rast_zb_addr,
    input  logic [7:0]        i_rast_zb_data,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [11:0]       o_fb_pixel,
    output logic              o_zb_we,
    output logic [ADDR_W-1:0] o_zb_addr,
    output logic [7:0]        o_zb_data
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              rast_we;

    assign rast_we = i_rast_fb_we | i_rast_zb_we;
    assign o_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            o_clear_done  <= 1'b0;
            o_err_overlap <= 1'b0;
            o_fb_we       <= 1'b0;
            o_fb_addr     <= '0;
            o_fb_pixel    <= '0;
            o_zb_we       <= 1'b0;
            o_zb_addr     <= '0;
            o_zb_data     <= '0;
        end else begin
            o_fb_we      <= 1'b0;
            o_zb_we      <= 1'b0;
            o_clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_fb_we    <= i_rast_fb_we;
                    o_fb_addr  <= i_rast_fb_addr;
                    o_fb_pixel <= i_rast_fb_pixel;
                    o_zb_we    <= i_rast_zb_we;
                    o_zb_addr  <= i_rast_zb_addr;
                    o_zb_data  <= i_rast_zb_data;
                    if (i_clear_req) begin
                        state         <= CLEAR;
                        cnt           <= '0;
                        o_err_overlap <= 1'b0;
                    end
                end
                CLEAR: begin
                    o_fb_we    <= 1'b1;
                    o_fb_addr  <= cnt;
                    o_fb_pixel <= CLEAR_COLOR;
                    o_zb_we    <= 1'b1;
                    o_zb_addr  <= cnt;
                    o_zb_data  <= CLEAR_Z;
                    if (rast_we) o_err_overlap <= 1'b1;
                    // Stop exactly on the last pixel; the counter never wraps mid-sweep.
                    if (cnt == LAST_ADDR) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                DONE: begin
                    o_clear_done <= 1'b1;
                    state        <= IDLE;
                    if (rast_we) o_err_overlap <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_clear_ctrl.sv
// Bench for frame_clear_ctrl: write-event scoreboard on FB and ZB ports plus
// directed checks for latency, overlap flag, mid-sweep reset and held requests.
module tb_frame_clear_ctrl;

    localparam int P = 1000;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_clear_req;
    logic          o_busy, o_clear_done, o_err_overlap;
    logic          i_rast_fb_we, i_rast_zb_we;
    logic [AW-1:0] i_rast_fb_addr, i_rast_zb_addr;
    logic [11:0]   i_rast_fb_pixel;
    logic [7:0]    i_rast_zb_data;
    logic          o_fb_we, o_zb_we;
    logic [AW-1:0] o_fb_addr, o_zb_addr;
    logic [11:0]   o_fb_pixel;
    logic [7:0]    o_zb_data;

    logic [31:0] exp_fb_q[$];
    logic [31:0] exp_zb_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;

    frame_clear_ctrl #(.NUM_PIXELS(P), .ADDR_W(AW), .CLEAR_COLOR(12'h000), .CLEAR_Z(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear_req(i_clear_req),
        .o_busy(o_busy), .o_clear_done(o_clear_done), .o_err_overlap(o_err_overlap),
        .i_rast_fb_we(i_rast_fb_we), .i_rast_fb_addr(i_rast_fb_addr), .i_rast_fb_pixel(i_rast_fb_pixel),
        .i_rast_zb_we(i_rast_zb_we), .i_rast_zb_addr(i_rast_zb_addr), .i_rast_zb_data(i_rast_zb_data),
        .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr), .o_fb_pixel(o_fb_pixel),
        .o_zb_we(o_zb_we), .o_zb_addr(o_zb_addr), .o_zb_data(o_zb_data)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got cycle %0d, required finish earlier", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_clear_done) done_cnt++;
            if (o_fb_we) begin
                if (exp_fb_q.size() == 0) chk("fb_unexpected_we", o_fb_we, 1'b0);
                else chk("fb_write", {3'b0, o_fb_addr, o_fb_pixel}, exp_fb_q.pop_front());
            end
            if (o_zb_we) begin
                if (exp_zb_q.size() == 0) chk("zb_unexpected_we", o_zb_we, 1'b0);
                else chk("zb_write", {7'b0, o_zb_addr, o_zb_data}, exp_zb_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < P; i++) begin
            exp_fb_q.push_back({3'b0, AW'(i), 12'h000});
            exp_zb_q.push_back({7'b0, AW'(i), 8'hFF});
        end
    endtask

    task automatic rast_write(input logic fe, input int fa, input int fp,
                              input logic ze, input int za, input int zd, input logic expect_fwd);
        i_rast_fb_we = fe; i_rast_fb_addr = AW'(fa); i_rast_fb_pixel = 12'(fp);
        i_rast_zb_we = ze; i_rast_zb_addr = AW'(za); i_rast_zb_data  = 8'(zd);
        if (expect_fwd && fe) exp_fb_q.push_back({3'b0, AW'(fa), 12'(fp)});
        if (expect_fwd && ze) exp_zb_q.push_back({7'b0, AW'(za), 8'(zd)});
        step(1);
        i_rast_fb_we = 1'b0; i_rast_zb_we = 1'b0;
    endtask

    // pulse request at the current drive slot; returns the sampling edge number
    task automatic pulse_req(output int n_edge);
        push_sweep();
        i_clear_req = 1'b1;
        n_edge = cyc + 1;
        step(1);
        i_clear_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_clear_done) begin
                at = i + 0;
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done_timeout", o_clear_done, 1'b1);
    endtask

    initial begin
        int n, at, d0;
        rst_n = 1'b0; i_clear_req = 1'b0;
        i_rast_fb_we = 1'b0; i_rast_fb_addr = '0; i_rast_fb_pixel = '0;
        i_rast_zb_we = 1'b0; i_rast_zb_addr = '0; i_rast_zb_data = '0;
        #12;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_clear_done, 0);
        chk("rst_err", o_err_overlap, 0);
        chk("rst_fb_we", o_fb_we, 0);
        chk("rst_zb_we", o_zb_we, 0);
        chk("rst_fb_addr", o_fb_addr, 0);
        chk("rst_zb_data", o_zb_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(2);

        // pass-through, independent enables
        rast_write(1, 1234, 'hABC, 0, 0, 0, 1);
        rast_write(0, 0, 0, 1, 99, 'h5A, 1);
        rast_write(1, 4321, 'h123, 1, 77, 'h10, 1);
        for (int i = 0; i < 20; i++)
            rast_write(1'($urandom_range(0, 1)), $urandom_range(0, P - 1), $urandom_range(0, 4095),
                       1'($urandom_range(0, 1)), $urandom_range(0, P - 1), $urandom_range(0, 255), 1);
        step(2);
        chk("pass_err", o_err_overlap, 0);

        // full sweep with latency
        d0 = done_cnt;
        pulse_req(n);
        @(negedge clk);
        chk("sweep_busy", o_busy, 1);
        wait_done(P + 10, at);
        chk("sweep_done_cycle", at, n + P + 1);
        @(negedge clk);
        chk("done_pulse_width", o_clear_done, 0);
        chk("sweep_done_count", done_cnt - d0, 1);
        chk("sweep_fb_drained", exp_fb_q.size(), 0);
        chk("sweep_busy_end", o_busy, 0);

        // request during sweep is ignored
        @(posedge clk); #1;
        d0 = done_cnt;
        pulse_req(n);
        step(500);
        i_clear_req = 1'b1;
        step(3);
        i_clear_req = 1'b0;
        wait_done(P + 10, at);
        chk("req_mid_done_cycle", at, n + P + 1);
        step(5);
        chk("req_mid_done_count", done_cnt - d0, 1);
        chk("req_mid_zb_drained", exp_zb_q.size(), 0);
        chk("req_mid_err", o_err_overlap, 0);

        // rasterizer write while busy is dropped and flagged
        pulse_req(n);
        step(100);
        rast_write(0, 0, 0, 1, 7, 'h11, 0);
        @(negedge clk);
        chk("overlap_set", o_err_overlap, 1);
        wait_done(P + 10, at);
        step(2);
        chk("overlap_sticky", o_err_overlap, 1);
        rast_write(1, 55, 'h777, 0, 0, 0, 1);
        step(1);
        chk("overlap_sticky_idle", o_err_overlap, 1);
        pulse_req(n);
        chk("overlap_cleared", o_err_overlap, 0);
        wait_done(P + 10, at);
        step(2);

        // reset mid-sweep, then restart from address 0
        pulse_req(n);
        step(600);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_fb_we", o_fb_we, 0);
        chk("midrst_zb_we", o_zb_we, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_fb_addr", o_fb_addr, 0);
        exp_fb_q.delete();
        exp_zb_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        step(3);
        chk("midrst_no_writes", o_fb_we, 0);
        pulse_req(n);
        wait_done(P + 10, at);
        chk("restart_done_cycle", at, n + P + 1);
        step(2);

        // request held through DONE: second sweep only after returning to IDLE
        d0 = done_cnt;
        push_sweep();
        push_sweep();
        i_clear_req = 1'b1;
        n = cyc + 1;
        wait_done(P + 10, at);
        chk("held_first_done", at, n + P + 1);
        @(posedge clk); #1 i_clear_req = 1'b0;
        wait_done(P + 10, at);
        chk("held_second_done", at, n + 2 * P + 3);
        step(5);
        chk("held_done_count", done_cnt - d0, 2);

        chk("final_fb_q_empty", exp_fb_q.size(), 0);
        chk("final_zb_q_empty", exp_zb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
